// File: rtl/spawn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spawn_pkg
// Description : Shared types and constants for the unit spawn controller.
// Revision    : 1.0
// ============================================================================
package spawn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_COOL   = 2'd3
  } spawn_state_t;

  localparam logic [1:0] DENY_NONE  = 2'b00;
  localparam logic [1:0] DENY_BUSY  = 2'b01;
  localparam logic [1:0] DENY_FUNDS = 2'b10;
  localparam logic [1:0] DENY_SLOT  = 2'b11;

  // Matches the unit slot's {left,right,down} decode
  localparam logic [2:0] TYPE_LEFT  = 3'b100;
  localparam logic [2:0] TYPE_RIGHT = 3'b010;
  localparam logic [2:0] TYPE_DOWN  = 3'b001;

endpackage
`default_nettype wire

// File: rtl/free_slot_finder.sv
`default_nettype none
// ============================================================================
// Module      : free_slot_finder
// Description : Lowest-index dead slot, as a one-hot select plus found flag.
// Revision    : 1.0
// ============================================================================
module free_slot_finder
  import spawn_pkg::*;
#(
  parameter int NUM_UNITS = 8
) (
  input  logic [NUM_UNITS-1:0] unitDead,
  output logic [NUM_UNITS-1:0] sel,
  output logic                 found
);

  // Isolates the lowest set bit
  assign sel   = unitDead & (~unitDead + NUM_UNITS'(1));
  assign found = |unitDead;

endmodule
`default_nettype wire

// File: rtl/spawn_controller.sv
`default_nettype none
// ============================================================================
// Module      : spawn_controller
// Description : Turns spawn buttons into a one-cycle spawn command for a free
//               slot, gated by energy budget, slot availability and cooldown.
// Revision    : 1.0
// ============================================================================
module spawn_controller
  import spawn_pkg::*;
#(
  parameter int NUM_UNITS  = 8,
  parameter int ENERGY_W   = 10,
  parameter int ENERGY_MAX = 999,
  parameter int TICK_GAIN  = 1,
  parameter int COST1      = 50,
  parameter int COST2      = 100,
  parameter int COST3      = 200,
  parameter int COOLDOWN   = 30,
  parameter int SETTLE_CYC = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 gameTick,
  input  logic                 btnLeft,
  input  logic                 btnRight,
  input  logic                 btnDown,
  input  logic [NUM_UNITS-1:0] unitDead,
  output logic [NUM_UNITS-1:0] spawnSel,
  output logic [2:0]           spawnType,
  output logic [ENERGY_W-1:0]  energy,
  output logic                 busy,
  output logic                 spawnDenied,
  output logic [1:0]           denyCode
);

  localparam int c_SW  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int c_CLW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic [ENERGY_W:0] c_COST1 = (ENERGY_W+1)'(COST1);
  localparam logic [ENERGY_W:0] c_COST2 = (ENERGY_W+1)'(COST2);
  localparam logic [ENERGY_W:0] c_COST3 = (ENERGY_W+1)'(COST3);
  localparam logic [ENERGY_W:0] c_GAIN  = (ENERGY_W+1)'(TICK_GAIN);
  localparam logic [ENERGY_W:0] c_MAX   = (ENERGY_W+1)'(ENERGY_MAX);
  localparam logic [c_SW-1:0]   c_SETTLE_LAST = c_SW'(SETTLE_CYC - 1);
  localparam logic [c_CLW-1:0]  c_COOL_INIT   = c_CLW'(COOLDOWN);

  spawn_state_t         r_state;
  logic [c_SW-1:0]      r_settle_cnt;
  logic [c_CLW-1:0]     r_cool_cnt;

  logic [NUM_UNITS-1:0] w_sel;
  logic                 w_found;
  logic                 w_req;
  logic                 w_idle;
  logic                 w_funds;
  logic                 w_go;
  logic [2:0]           w_type;
  logic [ENERGY_W:0]    w_cost;
  logic [ENERGY_W:0]    w_after_cost;
  logic [ENERGY_W:0]    w_sum;
  logic [ENERGY_W-1:0]  w_energy_next;

  free_slot_finder #(
    .NUM_UNITS (NUM_UNITS)
  ) u_finder (
    .unitDead (unitDead),
    .sel      (w_sel),
    .found    (w_found)
  );

  // Priority left > right > down; lower presses are simply ignored
  always_comb begin
    w_type = TYPE_DOWN;
    w_cost = c_COST3;
    if (btnLeft) begin
      w_type = TYPE_LEFT;
      w_cost = c_COST1;
    end else if (btnRight) begin
      w_type = TYPE_RIGHT;
      w_cost = c_COST2;
    end
  end

  assign w_req   = btnLeft | btnRight | btnDown;
  assign w_idle  = (r_state == ST_IDLE);
  assign w_funds = ({1'b0, energy} >= w_cost);
  assign w_go    = w_idle & w_req & w_funds & w_found;

  // Cost is checked against the pre-tick value; the extra bit keeps the
  // tick addition from wrapping before saturation.
  assign w_after_cost = {1'b0, energy} - (w_go ? w_cost : '0);
  assign w_sum        = w_after_cost + c_GAIN;

  always_comb begin
    w_energy_next = ENERGY_W'(w_after_cost);
    if (gameTick) w_energy_next = ENERGY_W'((w_sum > c_MAX) ? c_MAX : w_sum);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
      r_cool_cnt   <= '0;
      spawnSel     <= '0;
      spawnType    <= '0;
      energy       <= '0;
      busy         <= 1'b0;
      spawnDenied  <= 1'b0;
      denyCode     <= DENY_NONE;
    end else begin
      spawnSel    <= '0;
      spawnType   <= '0;
      spawnDenied <= 1'b0;
      energy      <= w_energy_next;

      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            if (!w_funds) begin
              spawnDenied <= 1'b1;
              denyCode    <= DENY_FUNDS;
            end else if (!w_found) begin
              spawnDenied <= 1'b1;
              denyCode    <= DENY_SLOT;
            end else begin
              spawnSel  <= w_sel;
              spawnType <= w_type;
              busy      <= 1'b1;
              r_state   <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          r_settle_cnt <= c_SETTLE_LAST;
          r_state      <= ST_SETTLE;
        end
        // Target slot still reads dead here, so nothing else is evaluated
        ST_SETTLE: begin
          if (r_settle_cnt == '0) begin
            if (COOLDOWN == 0) begin
              busy    <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_cool_cnt <= c_COOL_INIT;
              r_state    <= ST_COOL;
            end
          end else begin
            r_settle_cnt <= r_settle_cnt - 1'b1;
          end
        end
        ST_COOL: begin
          if (gameTick) begin
            r_cool_cnt <= r_cool_cnt - 1'b1;
            if (r_cool_cnt == c_CLW'(1)) begin
              busy    <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_req && !w_idle) begin
        spawnDenied <= 1'b1;
        denyCode    <= DENY_BUSY;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spawn_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_spawn_controller
// Description : Directed + random bench for spawn_controller against a model.
// Revision    : 1.0
// ============================================================================
module tb_spawn_controller;

  localparam int SETTLE_CYC = 2;
  localparam int COOLDOWN   = 30;

  logic       clk = 1'b0;
  logic       reset;
  logic       gameTick, btnLeft, btnRight, btnDown;
  logic [7:0] unitDead;
  logic [7:0] spawnSel;
  logic [2:0] spawnType;
  logic [9:0] energy;
  logic       busy, spawnDenied;
  logic [1:0] denyCode;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: energy as an integer, lockout as clk cycles then ticks
  int         m_energy;
  int         m_clks;
  int         m_ticks;
  logic [7:0] m_sel;
  logic [2:0] m_type;
  logic       m_den;
  logic [1:0] m_code;
  logic       m_busy;

  spawn_controller dut (
    .clk         (clk),
    .reset       (reset),
    .gameTick    (gameTick),
    .btnLeft     (btnLeft),
    .btnRight    (btnRight),
    .btnDown     (btnDown),
    .unitDead    (unitDead),
    .spawnSel    (spawnSel),
    .spawnType   (spawnType),
    .energy      (energy),
    .busy        (busy),
    .spawnDenied (spawnDenied),
    .denyCode    (denyCode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all();
    check("sel",    32'(spawnSel),    32'(m_sel));
    check("type",   32'(spawnType),   32'(m_type));
    check("energy", 32'(energy),      32'(m_energy));
    check("busy",   32'(busy),        32'(m_busy));
    check("denied", 32'(spawnDenied), 32'(m_den));
    check("code",   32'(denyCode),    32'(m_code));
  endtask

  task automatic model_reset();
    m_energy = 0; m_clks = 0; m_ticks = 0;
    m_sel = '0; m_type = '0; m_den = 1'b0; m_code = 2'b00; m_busy = 1'b0;
  endtask

  task automatic model_edge(input bit t, input bit l, input bit r, input bit d,
                            input logic [7:0] dead);
    int cost, slot;
    logic [2:0] ty;
    bit idle, spawn;
    idle  = (m_clks == 0) && (m_ticks == 0);
    m_sel = '0; m_type = '0; m_den = 1'b0;
    spawn = 0; cost = 0; ty = '0; slot = -1;
    if (l || r || d) begin
      if (!idle) begin
        m_den = 1'b1; m_code = 2'b01;
      end else begin
        if (l)      begin cost = 50;  ty = 3'b100; end
        else if (r) begin cost = 100; ty = 3'b010; end
        else        begin cost = 200; ty = 3'b001; end
        for (int i = 7; i >= 0; i--) if (dead[i]) slot = i;
        if (m_energy < cost) begin
          m_den = 1'b1; m_code = 2'b10;
        end else if (slot < 0) begin
          m_den = 1'b1; m_code = 2'b11;
        end else begin
          spawn  = 1;
          m_sel  = 8'd1 << slot;
          m_type = ty;
        end
      end
    end
    if (m_clks > 0) begin
      m_clks--;
      if (m_clks == 0) m_ticks = COOLDOWN;
    end else if (m_ticks > 0 && t) begin
      m_ticks--;
    end
    if (spawn) m_clks = 1 + SETTLE_CYC;
    else       cost = 0;
    m_energy = m_energy - cost;
    if (t) m_energy = (m_energy + 1 > 999) ? 999 : m_energy + 1;
    m_busy = !((m_clks == 0) && (m_ticks == 0));
  endtask

  task automatic step(input bit t, input bit l, input bit r, input bit d);
    gameTick = t; btnLeft = l; btnRight = r; btnDown = d;
    @(posedge clk);
    model_edge(t, l, r, d, unitDead);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    gameTick = 1'b0; btnLeft = 1'b0; btnRight = 1'b0; btnDown = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    unitDead = 8'hFF;
    do_reset();

    // 1: basic left spawn after 60 ticks
    ticks(60);
    check("t1_energy60", 32'(energy), 32'd60);
    step(0, 1, 0, 0);
    check("t1_sel",    32'(spawnSel),  32'h01);
    check("t1_type",   32'(spawnType), 32'b100);
    check("t1_energy", 32'(energy),    32'd10);
    step(0, 0, 0, 0);
    check("t1_type_one_clk", 32'(spawnType), 32'd0);

    // 2: right into slot 4 leaves 0, then press while busy
    do_reset();
    unitDead = 8'b1111_0000;
    ticks(100);
    step(0, 0, 1, 0);
    check("t2_sel",    32'(spawnSel),  32'h10);
    check("t2_type",   32'(spawnType), 32'b010);
    check("t2_energy", 32'(energy),    32'd0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    check("t2_denied", 32'(spawnDenied), 32'd1);
    check("t2_code",   32'(denyCode),    32'b01);

    // 3: one short of the cost
    do_reset();
    unitDead = 8'hFF;
    ticks(49);
    step(0, 1, 0, 0);
    check("t3_denied", 32'(spawnDenied), 32'd1);
    check("t3_code",   32'(denyCode),    32'b10);
    check("t3_sel",    32'(spawnSel),    32'd0);
    check("t3_energy", 32'(energy),      32'd49);

    // 4: no free slot
    do_reset();
    unitDead = 8'h00;
    ticks(300);
    step(0, 0, 0, 1);
    check("t4_denied", 32'(spawnDenied), 32'd1);
    check("t4_code",   32'(denyCode),    32'b11);

    // 5: simultaneous left+down, then full lockout
    do_reset();
    unitDead = 8'hFF;
    ticks(200);
    step(0, 1, 0, 1);
    check("t5_type",   32'(spawnType),   32'b100);
    check("t5_energy", 32'(energy),      32'd150);
    check("t5_nodeny", 32'(spawnDenied), 32'd0);
    repeat (SETTLE_CYC + 1) step(0, 0, 0, 0);
    check("t5_busy_cool", 32'(busy), 32'd1);
    ticks(COOLDOWN - 1);
    check("t5_busy_last", 32'(busy), 32'd1);
    ticks(1);
    check("t5_idle", 32'(busy), 32'd0);

    // 6: saturation, coincident tick on spend, reset mid-issue
    do_reset();
    ticks(1010);
    check("t6_sat", 32'(energy), 32'd999);
    step(1, 0, 0, 1);
    check("t6_energy", 32'(energy),    32'd800);
    check("t6_type",   32'(spawnType), 32'b001);
    do_reset();
    check("t6_rst_sel",    32'(spawnSel), 32'd0);
    check("t6_rst_energy", 32'(energy),   32'd0);

    // Random traffic against the model
    do_reset();
    unitDead = 8'hFF;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 15) == 0)
        unitDead = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      step(1'($urandom_range(0, 1)),
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
